// File: rtl/mac_pkg.sv
// Shared widths and state encoding for the dot-product sequencer and its DSP.
// Ports: none (package only).
// Operand widths match an 18x18 signed multiplier; the accumulator is 54 bits.
package mac_pkg;

   localparam int MAC_A_W = 18;
   localparam int MAC_B_W = 18;
   localparam int MAC_W   = 54;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/mac_dsp.sv
// Combinational signed multiply-add, dout = a*b + c, wrapping modulo 2^54.
// Ports: a/b signed operands in, c addend in, dout sum out; no clock.
// Every internal register stage is absent, so dout settles in the same cycle.
module mac_dsp
   import mac_pkg::*;
(
   input  logic [MAC_A_W-1:0] a,
   input  logic [MAC_B_W-1:0] b,
   input  logic [MAC_W-1:0]   c,
   output logic [MAC_W-1:0]   dout
);

   localparam int PW = MAC_A_W + MAC_B_W;

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;

   // Both operands are two's complement; widen to the full product width first
   // so the low PW bits of the multiply are the exact signed product.
   assign a_ext = {{(PW-MAC_A_W){a[MAC_A_W-1]}}, a};
   assign b_ext = {{(PW-MAC_B_W){b[MAC_B_W-1]}}, b};
   assign prod  = a_ext * b_ext;

   assign dout = {{(MAC_W-PW){prod[PW-1]}}, prod} + c;

endmodule

// File: rtl/mac_dot_seq.sv
// Streaming dot-product sequencer wrapped around an external combinational DSP.
// Ports: in_valid/in_ready/in_a/in_b operand stream; mac_a/b/c/dout DSP side;
//        out_valid/out_ready/out_data result stream (one result per LEN terms).
// Latency: result valid the cycle after the LEN-th accepted pair; in_ready is 0
// while a result is pending, so a stalled consumer stalls the operand stream.
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int LEN = 16
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAC_A_W-1:0] in_a,
   input  logic [MAC_B_W-1:0] in_b,
   output logic [MAC_A_W-1:0] mac_a,
   output logic [MAC_B_W-1:0] mac_b,
   output logic [MAC_W-1:0]   mac_c,
   input  logic [MAC_W-1:0]   mac_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MAC_W-1:0]   out_data
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             first;
   logic [MAC_W-1:0] acc;

   // Operands go straight to the DSP; the whole multiply-add fits in one cycle.
   assign mac_a = in_a;
   assign mac_b = in_b;

   // A fresh vector adds onto zero, so acc from the previous result never leaks.
   assign mac_c = first ? '0 : acc;

   // Handshake outputs are pure decodes of the state register.
   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_HOLD);
   assign out_data  = acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ACC;
         cnt   <= '0;
         first <= 1'b1;
         acc   <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               if (in_valid) begin
                  acc <= mac_dout;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     first <= 1'b1;
                     state <= ST_HOLD;
                  end else begin
                     cnt   <= cnt + CNT_W'(1);
                     first <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state <= ST_ACC;
               end
            end
            default: begin
               state <= ST_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_seq.sv
module tb_mac_dot_seq;
   import mac_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [17:0] in_a, in_b;

   logic        v4, r4, ov4, or4;
   logic [17:0] ma4, mb4;
   logic [53:0] mc4, md4, od4;
   logic        v1, r1, ov1, or1;
   logic [17:0] ma1, mb1;
   logic [53:0] mc1, md1, od1;

   mac_dot_seq #(.LEN(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4),
      .in_a(in_a), .in_b(in_b), .mac_a(ma4), .mac_b(mb4), .mac_c(mc4),
      .mac_dout(md4), .out_valid(ov4), .out_ready(or4), .out_data(od4));
   mac_dsp d4 (.a(ma4), .b(mb4), .c(mc4), .dout(md4));

   mac_dot_seq #(.LEN(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
      .in_a(in_a), .in_b(in_b), .mac_a(ma1), .mac_b(mb1), .mac_c(mc1),
      .mac_dout(md1), .out_valid(ov1), .out_ready(or1), .out_data(od1));
   mac_dsp d1 (.a(ma1), .b(mb1), .c(mc1), .dout(md1));

   // Scoreboard and reference model state
   logic [53:0] exp4[$];
   logic [53:0] exp1[$];
   longint      sum4;
   int          n4;
   int          vectors;
   int          errors;
   logic [53:0] last4, last1;
   logic        rand_rdy;

   task automatic chk(input string nm, input logic [53:0] act, input logic [53:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: dot product as plain signed integer arithmetic, wrapped to 54 bits.
   task automatic model(input bit one, input logic [17:0] a, input logic [17:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      if (one) begin
         exp1.push_back(54'(p));
      end else begin
         sum4 += p;
         n4++;
         if (n4 == 4) begin
            exp4.push_back(54'(sum4));
            sum4 = 0;
            n4 = 0;
         end
      end
   endtask

   task automatic push(input bit one, input logic [17:0] a, input logic [17:0] b);
      int g;
      g = 0;
      in_a = a;
      in_b = b;
      if (one) v1 = 1'b1; else v4 = 1'b1;
      while (!(one ? r1 : r4) && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 200) begin
         vectors++;
         errors++;
         $display("FAIL push_timeout: in_ready low for %0d cycles, expected 1", g);
         v1 = 1'b0;
         v4 = 1'b0;
      end else begin
         @(posedge clk); #1;
         v1 = 1'b0;
         v4 = 1'b0;
         model(one, a, b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp4.size() != 0 || exp1.size() != 0) && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 300) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0", exp4.size(), exp1.size());
         exp4.delete();
         exp1.delete();
      end
      idle(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v4 = 1'b0;
      v1 = 1'b0;
      exp4.delete();
      exp1.delete();
      sum4 = 0;
      n4 = 0;
      @(posedge clk); #1;
      chk("rst_out_valid4", 54'(ov4), 54'd0);
      chk("rst_in_ready4", 54'(r4), 54'd1);
      chk("rst_out_data4", od4, 54'd0);
      chk("rst_mac_c4", mc4, 54'd0);
      chk("rst_out_valid1", 54'(ov1), 54'd0);
      chk("rst_in_ready1", 54'(r1), 54'd1);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic vec1();
      push(0, 18'd1, 18'd5);
      push(0, 18'd2, 18'd6);
      push(0, 18'd3, 18'd7);
      push(0, 18'd4, 18'd8);
   endtask

   // Monitor for LEN=4: result checks, latency, pulse width, stability, bubble.
   int          hs4;
   logic        pend4, hold4, hsl4;
   logic [53:0] prevd4;
   always @(negedge clk) begin
      logic [53:0] e;
      if (reset) begin
         hs4 = 0; pend4 = 0; hold4 = 0; hsl4 = 0;
      end else begin
         if (pend4) chk("latency4", 54'(ov4), 54'd1);
         if (hsl4) chk("pulse4", 54'(ov4), 54'd0);
         if (hold4) begin
            chk("stable_valid4", 54'(ov4), 54'd1);
            chk("stable_data4", od4, prevd4);
         end
         if (ov4) chk("in_ready_hold4", 54'(r4), 54'd0);
         if (ov4 && or4) begin
            if (exp4.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected4: got result %h, expected none", od4);
            end else begin
               e = exp4.pop_front();
               chk("result4", od4, e);
               last4 = od4;
            end
         end
         pend4 = v4 && r4 && (hs4 == 3);
         if (v4 && r4) hs4 = (hs4 == 3) ? 0 : hs4 + 1;
         hold4  = ov4 && !or4;
         hsl4   = ov4 && or4;
         prevd4 = od4;
      end
   end

   // Monitor for LEN=1: every accepted pair yields a result next cycle.
   logic pend1;
   always @(negedge clk) begin
      logic [53:0] e;
      if (reset) begin
         pend1 = 0;
      end else begin
         if (pend1) chk("latency1", 54'(ov1), 54'd1);
         if (ov1 && or1) begin
            if (exp1.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected1: got result %h, expected none", od1);
            end else begin
               e = exp1.pop_front();
               chk("result1", od1, e);
               last1 = od1;
            end
         end
         pend1 = v1 && r1;
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         or4 = 1'($urandom_range(0, 1));
         or1 = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      vectors = 0; errors = 0; sum4 = 0; n4 = 0;
      last4 = '0; last1 = '0; rand_rdy = 1'b0;
      reset = 1'b1; v4 = 1'b0; v1 = 1'b0; or4 = 1'b1; or1 = 1'b1;
      in_a = '0; in_b = '0;
      hs4 = 0; pend4 = 0; hold4 = 0; hsl4 = 0; prevd4 = '0; pend1 = 0;
      do_reset();

      // Basic vector, back-to-back
      vec1();
      drain();
      chk("vec_70", last4, 54'h46);

      // Negative operand
      repeat (4) push(0, 18'h3FFFD, 18'd5);
      drain();
      chk("vec_neg60", last4, 54'h3F_FFFF_FFFF_FFC4);

      // Most-negative times most-negative
      repeat (4) push(0, 18'h20000, 18'h20000);
      drain();
      chk("vec_2p36", last4, 54'h10_0000_0000);

      // Back-pressure then next vector starts from zero
      or4 = 1'b0;
      vec1();
      idle(10);
      chk("bp_in_ready", 54'(r4), 54'd0);
      chk("bp_out_data", od4, 54'h46);
      or4 = 1'b1;
      drain();
      repeat (4) push(0, 18'd1, 18'd1);
      drain();
      chk("after_bp_4", last4, 54'd4);

      // in_valid every other cycle
      push(0, 18'd1, 18'd5); idle(1);
      push(0, 18'd2, 18'd6); idle(1);
      push(0, 18'd3, 18'd7); idle(1);
      push(0, 18'd4, 18'd8);
      drain();
      chk("gap_70", last4, 54'h46);

      // Reset mid-vector discards partial terms
      push(0, 18'd9, 18'd9);
      push(0, 18'd9, 18'd9);
      do_reset();
      vec1();
      drain();
      chk("rst_mid_70", last4, 54'h46);

      // Reset while a result is pending drops it
      or4 = 1'b0;
      vec1();
      idle(2);
      do_reset();
      or4 = 1'b1;
      idle(2);
      chk("rst_hold_valid", 54'(ov4), 54'd0);
      vec1();
      drain();
      chk("rst_hold_70", last4, 54'h46);

      // LEN=1
      repeat (3) push(1, 18'd100, 18'h3FFFE);
      drain();
      chk("len1_m200", last1, 54'h3F_FFFF_FFFF_FF38);

      // Randomized operands, gaps and back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 160; i++) begin
         push(0, 18'($urandom), 18'($urandom));
         idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 40; i++) begin
         push(1, 18'($urandom), 18'($urandom));
         idle($urandom_range(0, 1));
      end
      rand_rdy = 1'b0;
      idle(1);
      or4 = 1'b1;
      or1 = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
